// File: rtl/rx_serial_align_pkg.sv
// Shared PHY definitions for the receive serial aligner: alignment symbol,
// default lock constants, counter widths and the lane state encoding.
package phy_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned BAD_W  = 2;

   localparam logic [BYTE_W-1:0] COM_SYM = 8'hBC;

   localparam int unsigned COM_LOCK_DEF   = 4;
   localparam int unsigned LOSS_LIMIT_DEF = 2;

   // 2'd3 is unused; the FSM recovers from it to SEARCH
   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

endpackage : phy_pkg

// File: rtl/rx_serial_align_if.sv
// Lane interface between the serial bit source and the byte aligner.
//   data_in     : serial bit, MSB first
//   data_out    : last received data byte
//   valid_out   : data_out holds a non-COM byte received while locked
//   active      : lane locked
//   byte_strobe : one-cycle pulse per byte boundary once aligned
// master = upstream source / byte consumer, slave = aligner.
interface rx_serial_align_if;
   import phy_pkg::*;

   logic              data_in;
   logic [BYTE_W-1:0] data_out;
   logic              valid_out;
   logic              active;
   logic              byte_strobe;

   modport master (
      output data_in,
      input  data_out,
      input  valid_out,
      input  active,
      input  byte_strobe
   );

   modport slave (
      input  data_in,
      output data_out,
      output valid_out,
      output active,
      output byte_strobe
   );

endinterface : rx_serial_align_if

// File: rtl/rx_serial_align.sv
// Receive serial-to-parallel stage: recovers byte boundaries from a 1-bit
// MSB-first stream using repeated COM symbols, then emits data bytes.
//   clk_32f : bit-rate clock, all state updates on rising edge
//   reset   : asynchronous, active-high
//   lane    : rx_serial_align_if slave (data_in in; data_out, valid_out,
//             active, byte_strobe out, all registered)
module rx_serial_align
   import phy_pkg::*;
#(
   parameter int unsigned COM_LOCK   = COM_LOCK_DEF,
   parameter int unsigned LOSS_LIMIT = LOSS_LIMIT_DEF
) (
   input  logic             clk_32f,
   input  logic             reset,
   rx_serial_align_if.slave lane
);

   localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(COM_LOCK);
   localparam logic [BAD_W-1:0] LOSS_N = BAD_W'(LOSS_LIMIT);

   state_t            state;
   logic [BYTE_W-1:0] sr;
   logic [BIT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  com_cnt;
   logic [BAD_W-1:0]  bad_cnt;
   logic [BYTE_W-1:0] data_q;
   logic              valid_q;
   logic              active_q;
   logic              strobe_q;

   logic [BYTE_W-1:0] sr_next;
   logic              is_com;
   logic              boundary;
   logic [CNT_W-1:0]  com_inc;
   logic [BAD_W-1:0]  bad_inc;

   // Byte as it will look after this edge; compared against COM every edge
   assign sr_next  = {sr[BYTE_W-2:0], lane.data_in};
   assign is_com   = (sr_next == COM_SYM);
   assign boundary = (bit_cnt == '1);
   assign com_inc  = com_cnt + CNT_W'(1);
   assign bad_inc  = bad_cnt + BAD_W'(1);

   // Shifter, counters and lane FSM
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         state    <= SEARCH;
         sr       <= '0;
         bit_cnt  <= '0;
         com_cnt  <= '0;
         bad_cnt  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         active_q <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         sr       <= sr_next;
         strobe_q <= 1'b0;
         case (state)
            SEARCH: begin
               bit_cnt <= '0;
               if (is_com) begin
                  state   <= ALIGN;
                  com_cnt <= CNT_W'(1);
                  bad_cnt <= '0;
               end
            end
            ALIGN: begin
               bit_cnt <= bit_cnt + BIT_W'(1);
               if (boundary) begin
                  strobe_q <= 1'b1;
                  if (is_com) begin
                     bad_cnt <= '0;
                     com_cnt <= (com_cnt == LOCK_N) ? com_cnt : com_inc;
                     // lock edge updates state only; first data byte is next boundary
                     if (com_inc == LOCK_N) begin
                        state    <= ACTIVE;
                        active_q <= 1'b1;
                     end
                  end else begin
                     // a lone bad byte keeps phase but restarts the COM run
                     com_cnt <= '0;
                     bad_cnt <= bad_inc;
                     if (bad_inc == LOSS_N) begin
                        state   <= SEARCH;
                        bit_cnt <= '0;
                     end
                  end
               end
            end
            ACTIVE: begin
               bit_cnt <= bit_cnt + BIT_W'(1);
               if (boundary) begin
                  strobe_q <= 1'b1;
                  if (is_com) begin
                     valid_q <= 1'b0;
                  end else begin
                     data_q  <= sr_next;
                     valid_q <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= SEARCH;
               bit_cnt <= '0;
            end
         endcase
      end
   end

   assign lane.data_out    = data_q;
   assign lane.valid_out   = valid_q;
   assign lane.active      = active_q;
   assign lane.byte_strobe = strobe_q;

endmodule : rx_serial_align

// File: tb/tb_rx_serial_align.sv
// Scoreboard testbench for rx_serial_align. Each reset-delimited segment of
// bits is analysed by a byte-level reference model which queues the outputs
// expected at every byte strobe; a monitor checks strobes against the queue
// and checks that outputs hold between strobes.
module tb_rx_serial_align;
   import phy_pkg::*;

   localparam int unsigned LOCK = 4;
   localparam int unsigned LOSS = 2;
   localparam logic [7:0]  COM  = 8'hBC;

   typedef struct packed {
      logic       act;
      logic [7:0] data;
      logic       vld;
   } ev_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   rx_serial_align_if lane ();

   rx_serial_align #(
      .COM_LOCK   (LOCK),
      .LOSS_LIMIT (LOSS)
   ) dut (
      .clk_32f (clk),
      .reset   (reset),
      .lane    (lane)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   prints = 0;
   ev_t  exp_q[$];
   logic seg_bits[$];

   task automatic fail(input string name, input string detail);
      errors++;
      if (prints < 40) begin
         $display("FAIL %s: %s", name, detail);
         prints++;
      end
   endtask

   task automatic add_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) seg_bits.push_back(b[i]);
   endtask

   task automatic add_random_bits(input int n);
      for (int i = 0; i < n; i++) seg_bits.push_back(1'($urandom_range(0, 1)));
   endtask

   // Eight bits ending at stream index k; bits before the segment are zero
   function automatic logic [7:0] byte_at(input int k);
      logic [7:0] r = '0;
      for (int j = 0; j < 8; j++) begin
         int idx = k - 7 + j;
         r = {r[6:0], (idx >= 0) ? seg_bits[idx] : 1'b0};
      end
      return r;
   endfunction

   // Walk the segment: hunt bit by bit for COM, then step a byte at a time
   task automatic model_segment();
      int         n    = seg_bits.size();
      int         k    = 0;
      int         mode = 0;   // 0 hunting, 1 counting COMs, 2 locked
      int         com  = 0;
      int         bad  = 0;
      logic       act  = 1'b0;
      logic [7:0] d    = '0;
      logic       v    = 1'b0;
      logic [7:0] b;
      ev_t        e;
      while (k < n) begin
         b = byte_at(k);
         if (mode == 0) begin
            if (b == COM) begin
               mode = 1; com = 1; bad = 0; k += 8;
            end else begin
               k++;
            end
         end else if (mode == 1) begin
            if (b == COM) begin
               com++; bad = 0;
               if (com == int'(LOCK)) begin mode = 2; act = 1'b1; end
            end else begin
               com = 0; bad++;
            end
            e.act = act; e.data = d; e.vld = v;
            exp_q.push_back(e);
            if (mode == 1 && bad == int'(LOSS)) begin
               mode = 0; k += 1;
            end else begin
               k += 8;
            end
         end else begin
            if (b != COM) begin d = b; v = 1'b1; end
            else v = 1'b0;
            e.act = act; e.data = d; e.vld = v;
            exp_q.push_back(e);
            k += 8;
         end
      end
   endtask

   // Queue expectations, then drive the segment; returns 3ns after the last edge
   task automatic run_segment();
      model_segment();
      foreach (seg_bits[i]) begin
         @(negedge clk);
         lane.data_in = seg_bits[i];
      end
      @(posedge clk);
      #3;
   endtask

   task automatic check_cleared(input string name);
      checks++;
      if (lane.data_out !== 8'h00 || lane.valid_out !== 1'b0 ||
          lane.active !== 1'b0 || lane.byte_strobe !== 1'b0)
         fail(name, $sformatf("got data=%h valid=%b active=%b strobe=%b, want all zero",
              lane.data_out, lane.valid_out, lane.active, lane.byte_strobe));
   endtask

   task automatic do_reset(input string name);
      checks++;
      if (exp_q.size() != 0)
         fail({name, "_missing_strobes"}, $sformatf("%0d expected strobes not seen, want 0", exp_q.size()));
      exp_q.delete();
      reset = 1'b1;
      #1;
      check_cleared({name, "_reset"});
      lane.data_in = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      seg_bits.delete();
   endtask

   // Monitor: pop on each strobe, otherwise outputs must hold their last values
   initial begin
      ev_t held = '0;
      ev_t got;
      ev_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            held = '0;
            continue;
         end
         got.act = lane.active; got.data = lane.data_out; got.vld = lane.valid_out;
         checks++;
         if (lane.byte_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_strobe", $sformatf("strobe=1 at %0t, want 0", $time));
            end else begin
               e = exp_q.pop_front();
               held = e;
               if (got !== e)
                  fail("strobe_outputs", $sformatf("at %0t got act=%b data=%h vld=%b, want act=%b data=%h vld=%b",
                       $time, got.act, got.data, got.vld, e.act, e.data, e.vld));
            end
         end else if (lane.byte_strobe !== 1'b0 || got !== held) begin
            fail("hold_outputs", $sformatf("at %0t got strobe=%b act=%b data=%h vld=%b, want strobe=0 act=%b data=%h vld=%b",
                 $time, lane.byte_strobe, got.act, got.data, got.vld, held.act, held.data, held.vld));
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      lane.data_in = 1'b0;

      // Reset held with random bits: outputs stay cleared, state is SEARCH
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         lane.data_in = 1'($urandom_range(0, 1));
         check_cleared("reset_hold");
      end
      lane.data_in = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (dut.state != SEARCH)
         fail("reset_state", $sformatf("state=%0d, want %0d", dut.state, SEARCH));
      check_cleared("reset_release");
      do_reset("pre_offset");

      // Lock with a 3-bit offset, then data / COM / data
      seg_bits.push_back(1'b1); seg_bits.push_back(1'b0); seg_bits.push_back(1'b1);
      repeat (4) add_byte(COM);
      add_byte(8'h12); add_byte(COM); add_byte(8'h34);
      run_segment();
      checks++;
      if (lane.data_out !== 8'h34 || lane.valid_out !== 1'b1 || lane.active !== 1'b1)
         fail("offset_final", $sformatf("data=%h valid=%b active=%b, want 34 1 1",
              lane.data_out, lane.valid_out, lane.active));
      do_reset("offset");

      // Lock abort, then a fresh lock
      repeat (2) add_byte(COM);
      add_byte(8'h55); add_byte(8'h55);
      add_random_bits(5);
      repeat (4) add_byte(COM);
      add_byte(8'h77);
      run_segment();
      checks++;
      if (lane.data_out !== 8'h77 || lane.valid_out !== 1'b1 || lane.active !== 1'b1)
         fail("abort_relock", $sformatf("data=%h valid=%b active=%b, want 77 1 1",
              lane.data_out, lane.valid_out, lane.active));
      do_reset("abort");

      // Single glitch byte keeps phase
      repeat (2) add_byte(COM);
      add_byte(8'h00);
      repeat (4) add_byte(COM);
      add_byte(8'h3C);
      run_segment();
      checks++;
      if (lane.data_out !== 8'h3C || lane.valid_out !== 1'b1 || lane.active !== 1'b1)
         fail("glitch_lock", $sformatf("data=%h valid=%b active=%b, want 3c 1 1",
              lane.data_out, lane.valid_out, lane.active));
      do_reset("glitch");

      // Reset three bits into 8'hA5 while locked, then relock
      repeat (4) add_byte(COM);
      add_byte(8'h66);
      seg_bits.push_back(1'b1); seg_bits.push_back(1'b0); seg_bits.push_back(1'b1);
      run_segment();
      do_reset("mid_byte");
      repeat (4) add_byte(COM);
      add_byte(8'h5A);
      run_segment();
      do_reset("relock");

      // Back-to-back data after lock
      repeat (4) add_byte(COM);
      for (int i = 1; i <= 16; i++) add_byte(8'(i));
      run_segment();
      checks++;
      if (lane.data_out !== 8'h10 || lane.valid_out !== 1'b1)
         fail("b2b_final", $sformatf("data=%h valid=%b, want 10 1", lane.data_out, lane.valid_out));
      do_reset("b2b");

      // Random segments: junk, optional COM preamble, mixed bytes and slips
      for (int s = 0; s < 12; s++) begin
         add_random_bits($urandom_range(0, 20));
         if ($urandom_range(0, 9) < 7) repeat ($urandom_range(2, 5)) add_byte(COM);
         for (int b = 0; b < 30; b++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3: add_byte(COM);
               4:          add_random_bits($urandom_range(1, 7));
               default:    add_byte(8'($urandom));
            endcase
         end
         add_random_bits($urandom_range(0, 7));
         run_segment();
         do_reset("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rx_serial_align

// File: doc/rx_serial_align.md
Name: rx_serial_align

Overview:
- Receive-side serial-to-parallel stage of the PHY lane. It sits directly downstream of the transmit serializer and upstream of the receive byte-lane logic.
- Recovers byte boundaries from a 1-bit stream, MSB first, using repeated COM (8'hBC) symbols.
- After lock, emits 8-bit bytes with a valid flag. COM bytes received after lock are treated as idle.
- One instance per lane; four lanes are instantiated by the PHY top.

Parameters:
- COM, 8'hBC, alignment/idle symbol.
- COM_LOCK, 4, consecutive aligned COM bytes required to enter ACTIVE (legal range 2..15).
- LOSS_LIMIT, 2, consecutive non-COM bytes in ALIGN that return to SEARCH (legal range 1..3).

Ports:
- clk_32f  input  1  bit-rate clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  1  serial bit, sampled every rising edge.
- data_out  output  8  last received data byte.
- valid_out  output  1  data_out holds a non-COM byte received in ACTIVE.
- active  output  1  lane locked (state == ACTIVE).
- byte_strobe  output  1  one-cycle pulse at each byte boundary once aligned.

Behaviour:
- Reset values (async, immediate):
  - Outputs: data_out=8'h00, valid_out=0, active=0, byte_strobe=0.
  - Internal: shift reg=8'h00, bit_cnt=0, com_cnt=0, bad_cnt=0, state=SEARCH.
- Shift register: every edge, sr_next = {sr[6:0], data_in}. Bits arrive MSB first.
- bit_cnt runs 0..7 in ALIGN and ACTIVE and is held at 0 in SEARCH.
- A boundary edge is an edge where bit_cnt==7; on that edge sr_next is the completed byte and bit_cnt wraps to 0.
- SEARCH:
  - COM is checked on every edge. If sr_next==COM: go to ALIGN, bit_cnt<=0, com_cnt<=1, bad_cnt<=0.
- ALIGN (at boundary edges only):
  - sr_next==COM: com_cnt+1 and bad_cnt<=0. If com_cnt+1==COM_LOCK, go to ACTIVE.
  - sr_next!=COM: bad_cnt+1 and com_cnt<=0. If bad_cnt+1==LOSS_LIMIT, go to SEARCH with bit_cnt<=0.
  - A single non-COM byte (LOSS_LIMIT>1) keeps the current byte phase and restarts the COM count.
- ACTIVE (at boundary edges only):
  - sr_next!=COM: data_out<=sr_next, valid_out<=1.
  - sr_next==COM: valid_out<=0 and data_out is held.
  - ACTIVE is left only by reset.
- byte_strobe:
  - Registered, high for exactly the cycle after each boundary edge in ALIGN and ACTIVE.
  - Low in SEARCH, including the cycle after the edge that enters ALIGN.
- active: registered, asserted the cycle after the COM_LOCK-th COM boundary edge.
- Output hold and latency:
  - data_out and valid_out change only at boundary edges; hold for 8 cycles.
  - Latency: a byte's last bit sampled at edge N is visible on data_out after edge N.
- Simultaneous events:
  - A boundary edge that completes lock updates state only. The first data byte is the next boundary.
  - Reset mid-byte discards the partial byte; outputs go to their reset values immediately.
- Width rules:
  - com_cnt is 4 bits and saturates at COM_LOCK.
  - bad_cnt is 2 bits.
  - All counters wrap or saturate without overflow side effects.

Decomposition:
- Shared package phy_pkg holds:
  - COM_SYM=8'hBC;
  - state encoding SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2 (2'd3 illegal: next state SEARCH);
  - default lock constants.
- No sub-module: the shifter, counters and FSM form a single module.
- Four instances per PHY, one per lane; the rx top handles lane-to-lane skew.

Test Plan:
- Reset check: hold reset, drive random bits, release reset. All outputs stay at reset values; state reads SEARCH.
- Lock with offset:
  - Stimulus: 3 junk bits 101, then 4 COM bytes 8'hBC, then bytes 8'h12, 8'hBC, 8'h34.
  - active rises 1 cycle after the 4th COM's last bit.
  - data_out=8'h12 with valid_out=1 for 8 cycles, then valid_out=0 with data_out held at 8'h12, then data_out=8'h34 with valid_out=1.
  - byte_strobe pulses every 8 cycles from the 2nd COM on.
- Lock abort:
  - Stimulus: 2 COM, then 8'h55, 8'h55.
  - Returns to SEARCH; active stays 0 and byte_strobe stops.
  - A fresh 4-COM sequence then locks normally.
- Single glitch byte: 2 COM, then 8'h00, then 4 COM. Lock is achieved after the last 4 COM with byte phase unchanged.
- Reset mid-operation: assert reset 3 bits into data byte 8'hA5 while ACTIVE. Outputs clear immediately; relock requires 4 fresh COM.
- Back-to-back data: after lock, stream 8'h01 to 8'h10 with no COM. valid_out stays 1 and data_out increments once per 8 cycles.
